// File: rtl/vid_timing_gen.sv
// vid_timing_gen: raster timing and line-fetch sequencer.
// Generates hcnt/vcnt, registered sync/blank decodes, pixel strobes and one
// start-address request per displayed line for the bus-master fetch stage.
module vid_timing_gen #(
  parameter int CW = 13,
  parameter int AW = 32
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_en,
  input  logic [5:0]    i_pcnt,
  input  logic [CW-1:0] i_hsize,
  input  logic [CW-1:0] i_hend,
  input  logic [CW-1:0] i_hs_start,
  input  logic [CW-1:0] i_hs_end,
  input  logic [CW-1:0] i_vsize,
  input  logic [CW-1:0] i_vend,
  input  logic [CW-1:0] i_vs_start,
  input  logic [CW-1:0] i_vs_end,
  input  logic [AW-1:0] i_base_address,
  input  logic [AW-1:0] i_lineinc,
  input  logic          i_fetch_ack,
  output logic [CW-1:0] o_hcnt,
  output logic [CW-1:0] o_vcnt,
  output logic          o_hsync,
  output logic          o_hblank,
  output logic          o_vsync,
  output logic          o_vblank,
  output logic          o_pix_stb,
  output logic          o_frame_start,
  output logic          o_fetch_req,
  output logic [AW-1:0] o_fetch_addr,
  output logic          o_fetch_ovf
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_nextState;

  // Configuration captured on the IDLE->RUN transition
  logic [5:0]    r_pcnt;
  logic [CW-1:0] r_hsize, r_hend, r_hsStart, r_hsEnd;
  logic [CW-1:0] r_vsize, r_vend, r_vsStart, r_vsEnd;
  logic [AW-1:0] r_base, r_lineinc;

  // Raster state and registered outputs
  logic [5:0]    r_dcnt;
  logic [CW-1:0] r_hcnt, r_vcnt;
  logic          r_hsync, r_hblank, r_vsync, r_vblank;
  logic          r_pixStb, r_frameStart;
  logic          r_fetchReq, r_fetchOvf;
  logic [AW-1:0] r_fetchAddr;

  // Combinational helpers
  logic          w_enter, w_stay, w_adv, w_hWrap;
  logic          w_trig, w_trigValid;
  logic [CW-1:0] w_nextH, w_nextV, w_nl;
  logic [CW-1:0] w_cfgHsize, w_cfgHsStart, w_cfgHsEnd;
  logic [CW-1:0] w_cfgVsize, w_cfgVsStart, w_cfgVsEnd;
  logic [AW-1:0] w_cfgBase, w_cfgLineinc, w_fetchAddr;
  logic          w_hblankN, w_vblankN, w_hsyncN, w_vsyncN;

  // Next-state logic: enable starts a run, dropping enable ends it
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: if (i_en)  w_nextState = ST_RUN;
      ST_RUN:  if (!i_en) w_nextState = ST_IDLE;
      default: w_nextState = ST_IDLE;
    endcase
  end

  // In IDLE the live inputs describe the run about to start; in RUN only the latched copy counts
  always_comb begin
    w_cfgHsize   = r_hsize;
    w_cfgHsStart = r_hsStart;
    w_cfgHsEnd   = r_hsEnd;
    w_cfgVsize   = r_vsize;
    w_cfgVsStart = r_vsStart;
    w_cfgVsEnd   = r_vsEnd;
    w_cfgBase    = r_base;
    w_cfgLineinc = r_lineinc;
    if (r_state == ST_IDLE) begin
      w_cfgHsize   = i_hsize;
      w_cfgHsStart = i_hs_start;
      w_cfgHsEnd   = i_hs_end;
      w_cfgVsize   = i_vsize;
      w_cfgVsStart = i_vs_start;
      w_cfgVsEnd   = i_vs_end;
      w_cfgBase    = i_base_address;
      w_cfgLineinc = i_lineinc;
    end
  end

  // Counter advance, next raster position, decodes and fetch trigger for the coming edge
  always_comb begin
    w_enter = (r_state == ST_IDLE) && i_en;
    w_stay  = (r_state == ST_RUN) && i_en;
    w_adv   = w_stay && (r_dcnt == r_pcnt);
    w_hWrap = w_adv && (r_hcnt == r_hend);

    w_nextH = r_hcnt;
    w_nextV = r_vcnt;
    if (w_enter) begin
      w_nextH = '0;
      w_nextV = '0;
    end else if (w_adv) begin
      w_nextH = w_hWrap ? '0 : r_hcnt + CW'(1);
      if (w_hWrap) begin
        w_nextV = (r_vcnt == r_vend) ? '0 : r_vcnt + CW'(1);
      end
    end

    w_hblankN = (w_nextH >= w_cfgHsize);
    w_vblankN = (w_nextV >= w_cfgVsize);
    w_hsyncN  = (w_nextH >= w_cfgHsStart) && (w_nextH < w_cfgHsEnd);
    w_vsyncN  = (w_nextV >= w_cfgVsStart) && (w_nextV < w_cfgVsEnd);

    w_trig = w_enter || (w_adv && (w_nextH == r_hsize));
    if (w_enter) begin
      w_nl = '0;
    end else begin
      w_nl = (w_nextV == r_vend) ? '0 : w_nextV + CW'(1);
    end
    w_trigValid = w_trig && (w_nl < w_cfgVsize);
    w_fetchAddr = w_cfgBase + (AW'(w_nl) * w_cfgLineinc);
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_reset) r_state <= ST_IDLE;
    else          r_state <= w_nextState;
  end

  // Capture the timing/address configuration for the whole run
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_pcnt    <= '0;
      r_hsize   <= '0;
      r_hend    <= '0;
      r_hsStart <= '0;
      r_hsEnd   <= '0;
      r_vsize   <= '0;
      r_vend    <= '0;
      r_vsStart <= '0;
      r_vsEnd   <= '0;
      r_base    <= '0;
      r_lineinc <= '0;
    end else if (w_enter) begin
      r_pcnt    <= i_pcnt;
      r_hsize   <= i_hsize;
      r_hend    <= i_hend;
      r_hsStart <= i_hs_start;
      r_hsEnd   <= i_hs_end;
      r_vsize   <= i_vsize;
      r_vend    <= i_vend;
      r_vsStart <= i_vs_start;
      r_vsEnd   <= i_vs_end;
      r_base    <= i_base_address;
      r_lineinc <= i_lineinc;
    end
  end

  // Divider, raster counters, strobes and decodes; everything is zero outside a run
  always_ff @(posedge i_clk) begin
    if (!i_reset || !(w_enter || w_stay)) begin
      r_dcnt       <= '0;
      r_hcnt       <= '0;
      r_vcnt       <= '0;
      r_hsync      <= 1'b0;
      r_hblank     <= 1'b0;
      r_vsync      <= 1'b0;
      r_vblank     <= 1'b0;
      r_pixStb     <= 1'b0;
      r_frameStart <= 1'b0;
    end else begin
      r_dcnt       <= (w_enter || w_adv) ? 6'd0 : r_dcnt + 6'd1;
      r_hcnt       <= w_nextH;
      r_vcnt       <= w_nextV;
      r_hsync      <= w_hsyncN;
      r_hblank     <= w_hblankN;
      r_vsync      <= w_vsyncN;
      r_vblank     <= w_vblankN;
      r_pixStb     <= w_adv;
      r_frameStart <= w_enter || (w_adv && (w_nextH == '0) && (w_nextV == '0));
    end
  end

  // Fetch request handshake: hold until acked, chain back-to-back on ack+trigger, flag lost triggers
  always_ff @(posedge i_clk) begin
    if (!i_reset || !(w_enter || w_stay)) begin
      r_fetchReq  <= 1'b0;
      r_fetchAddr <= '0;
      r_fetchOvf  <= 1'b0;
    end else if (w_enter) begin
      r_fetchReq  <= w_trigValid;
      r_fetchAddr <= w_trigValid ? w_fetchAddr : '0;
      r_fetchOvf  <= 1'b0;
    end else if (w_trigValid) begin
      if (!r_fetchReq || i_fetch_ack) begin
        r_fetchReq  <= 1'b1;
        r_fetchAddr <= w_fetchAddr;
      end else begin
        r_fetchOvf <= 1'b1;
      end
    end else if (r_fetchReq && i_fetch_ack) begin
      r_fetchReq <= 1'b0;
    end
  end

  assign o_hcnt        = r_hcnt;
  assign o_vcnt        = r_vcnt;
  assign o_hsync       = r_hsync;
  assign o_hblank      = r_hblank;
  assign o_vsync       = r_vsync;
  assign o_vblank      = r_vblank;
  assign o_pix_stb     = r_pixStb;
  assign o_frame_start = r_frameStart;
  assign o_fetch_req   = r_fetchReq;
  assign o_fetch_addr  = r_fetchAddr;
  assign o_fetch_ovf   = r_fetchOvf;

endmodule

// File: tb/tb_vid_timing_gen.sv
// tb_vid_timing_gen: directed scenarios plus a cycle-by-cycle raster/fetch model.
module tb_vid_timing_gen;
  localparam int CW = 13;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          reset, en, fetchAck;
  logic [5:0]    pcnt;
  logic [CW-1:0] hsize, hend, hsStart, hsEnd, vsize, vend, vsStart, vsEnd;
  logic [AW-1:0] baseAddress, lineinc;
  logic [CW-1:0] hcnt, vcnt;
  logic          hsync, hblank, vsync, vblank, pixStb, frameStart, fetchReq, fetchOvf;
  logic [AW-1:0] fetchAddr;

  int total = 0;
  int bad   = 0;
  int ackMode = 0;

  vid_timing_gen #(.CW(CW), .AW(AW)) dut (
    .i_clk(clk), .i_reset(reset), .i_en(en), .i_pcnt(pcnt),
    .i_hsize(hsize), .i_hend(hend), .i_hs_start(hsStart), .i_hs_end(hsEnd),
    .i_vsize(vsize), .i_vend(vend), .i_vs_start(vsStart), .i_vs_end(vsEnd),
    .i_base_address(baseAddress), .i_lineinc(lineinc), .i_fetch_ack(fetchAck),
    .o_hcnt(hcnt), .o_vcnt(vcnt), .o_hsync(hsync), .o_hblank(hblank),
    .o_vsync(vsync), .o_vblank(vblank), .o_pix_stb(pixStb),
    .o_frame_start(frameStart), .o_fetch_req(fetchReq),
    .o_fetch_addr(fetchAddr), .o_fetch_ovf(fetchOvf)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int pc, input int hsz, input int hen, input int hss, input int hse,
                               input int vsz, input int ven, input int vss, input int vse,
                               input logic [31:0] base, input logic [31:0] linc);
    pcnt = 6'(pc);
    hsize = CW'(hsz); hend = CW'(hen); hsStart = CW'(hss); hsEnd = CW'(hse);
    vsize = CW'(vsz); vend = CW'(ven); vsStart = CW'(vss); vsEnd = CW'(vse);
    baseAddress = base; lineinc = linc;
  endtask

  task automatic checkIdle(input string name);
    checkOutput({name, "_cnt"}, {38'd0, hcnt, vcnt}, 64'd0);
    checkOutput({name, "_flags"}, {56'd0, hsync, hblank, vsync, vblank, pixStb, frameStart, fetchReq, fetchOvf}, 64'd0);
    checkOutput({name, "_addr"}, {32'd0, fetchAddr}, 64'd0);
  endtask

  task automatic waitPos(input int h, input int v, input int budget);
    int n = 0;
    while (!(int'(hcnt) == h && int'(vcnt) == v) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      total++;
      bad++;
      $display("[TB] FAIL wait_pos actual=timeout required=hcnt %0d vcnt %0d", h, v);
    end
  endtask

  // Fetch acknowledge: either tied low or echoes a visible request one sample later
  initial begin
    fetchAck = 1'b0;
    forever begin
      @(negedge clk);
      fetchAck = (ackMode == 1) ? fetchReq : 1'b0;
    end
  end

  // Behavioural model: position derived from elapsed clocks since run entry
  bit mRun = 0;
  int mT = 0;
  int mPcnt, mHsize, mHend, mHss, mHse, mVsize, mVend, mVss, mVse;
  logic [31:0] mBase, mLinc, mAddr;
  bit mReq = 0, mOvf = 0;
  bit mAck, mValid;
  int mNl;

  function automatic int mPix();
    return mT / (mPcnt + 1);
  endfunction
  function automatic int mH();
    return mPix() % (mHend + 1);
  endfunction
  function automatic int mV();
    return (mPix() / (mHend + 1)) % (mVend + 1);
  endfunction
  function automatic bit mStb();
    return (mT > 0) && ((mT % (mPcnt + 1)) == 0);
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (!reset) begin
        mRun = 0; mReq = 0; mAddr = 0; mOvf = 0; mT = 0;
      end else if (!mRun) begin
        if (en) begin
          mRun = 1; mT = 0;
          mPcnt = int'(pcnt); mHsize = int'(hsize); mHend = int'(hend);
          mHss = int'(hsStart); mHse = int'(hsEnd); mVsize = int'(vsize);
          mVend = int'(vend); mVss = int'(vsStart); mVse = int'(vsEnd);
          mBase = baseAddress; mLinc = lineinc;
          mOvf = 0; mReq = (mVsize > 0); mAddr = mReq ? mBase : 32'd0;
        end
      end else if (!en) begin
        mRun = 0; mReq = 0; mAddr = 0; mOvf = 0;
      end else begin
        mAck = mReq && fetchAck;
        mT++;
        mValid = 0;
        mNl = 0;
        if (mStb() && mH() == mHsize) begin
          mNl = (mV() == mVend) ? 0 : mV() + 1;
          mValid = (mNl < mVsize);
        end
        if (mValid) begin
          if (!mReq || mAck) begin
            mReq = 1;
            mAddr = mBase + 32'(mNl) * mLinc;
          end else begin
            mOvf = 1;
          end
        end else if (mAck) begin
          mReq = 0;
        end
      end
    end
  end

  // Compare DUT against the model every cycle, away from the active edge
  initial begin
    int eh, ev;
    bit es;
    forever begin
      @(negedge clk);
      eh = mRun ? mH() : 0;
      ev = mRun ? mV() : 0;
      es = mRun && mStb();
      checkOutput("model_hcnt", 64'(hcnt), 64'(eh));
      checkOutput("model_vcnt", 64'(vcnt), 64'(ev));
      checkOutput("model_hblank", 64'(hblank), 64'(mRun && eh >= mHsize));
      checkOutput("model_vblank", 64'(vblank), 64'(mRun && ev >= mVsize));
      checkOutput("model_hsync", 64'(hsync), 64'(mRun && eh >= mHss && eh < mHse));
      checkOutput("model_vsync", 64'(vsync), 64'(mRun && ev >= mVss && ev < mVse));
      checkOutput("model_pix_stb", 64'(pixStb), 64'(es));
      checkOutput("model_frame_start", 64'(frameStart), 64'(mRun && (mT == 0 || (es && eh == 0 && ev == 0))));
      checkOutput("model_fetch_req", 64'(fetchReq), 64'(mReq));
      checkOutput("model_fetch_ovf", 64'(fetchOvf), 64'(mOvf));
      if (mReq || !mRun) checkOutput("model_fetch_addr", 64'(fetchAddr), 64'(mAddr));
    end
  end

  // Directed scenarios with hand-computed expectations
  initial begin
    int hSeq[48], vSeq[48], hbSeq[48], hsSeq[48], vbSeq[48], vsSeq[48];
    int fsQ[$], reqK[$], stbQ[$];
    logic [31:0] reqA[$];
    bit prevReq;
    logic [31:0] prevAddr;
    int expH[8]  = '{0, 1, 2, 3, 4, 5, 0, 1};
    int expHb[8] = '{0, 0, 0, 0, 1, 1, 0, 0};
    int expHs[8] = '{0, 0, 0, 0, 1, 0, 0, 0};
    int expK[5]  = '{0, 4, 22, 28, 46};
    logic [31:0] expA[5] = '{32'h1000, 32'h1100, 32'h1000, 32'h1100, 32'h1000};
    int expStb[4] = '{3, 6, 9, 12};
    int hbCount;

    reset = 1'b0; en = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);

    // Reset held with enable high, then released with enable low
    repeat (3) begin @(negedge clk); checkIdle("t1_reset"); end
    reset = 1'b1; en = 1'b0;
    repeat (2) begin @(negedge clk); checkIdle("t1_idle"); end

    // Basic raster and fetch addresses with prompt acknowledge
    applyStimulus(0, 4, 5, 4, 5, 2, 3, 2, 3, 32'h1000, 32'h100);
    ackMode = 1; en = 1'b1;
    prevReq = 0; prevAddr = 0;
    for (int k = 0; k < 48; k++) begin
      @(negedge clk);
      hSeq[k] = int'(hcnt); hbSeq[k] = int'(hblank); hsSeq[k] = int'(hsync);
      vbSeq[k] = int'(vblank); vsSeq[k] = int'(vsync);
      if (frameStart) fsQ.push_back(k);
      if (fetchReq && (!prevReq || fetchAddr != prevAddr)) begin
        reqK.push_back(k); reqA.push_back(fetchAddr);
      end
      prevReq = fetchReq; prevAddr = fetchAddr;
    end
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("t2_hcnt_%0d", i), 64'(hSeq[i]), 64'(expH[i]));
      checkOutput($sformatf("t2_hblank_%0d", i), 64'(hbSeq[i]), 64'(expHb[i]));
      checkOutput($sformatf("t2_hsync_%0d", i), 64'(hsSeq[i]), 64'(expHs[i]));
    end
    checkOutput("t2_vblank_line1", 64'(vbSeq[6]), 64'd0);
    checkOutput("t2_vblank_line2", 64'(vbSeq[12]), 64'd1);
    checkOutput("t2_vsync_line2", 64'(vsSeq[12]), 64'd1);
    checkOutput("t2_vblank_line3", 64'(vbSeq[18]), 64'd1);
    checkOutput("t2_vsync_line3", 64'(vsSeq[18]), 64'd0);
    checkOutput("t2_fs_count", 64'(fsQ.size()), 64'd2);
    if (fsQ.size() >= 2) begin
      checkOutput("t2_fs_first", 64'(fsQ[0]), 64'd0);
      checkOutput("t2_fs_second", 64'(fsQ[1]), 64'd24);
    end
    checkOutput("t3_req_count", 64'(reqK.size()), 64'd5);
    for (int i = 0; i < 5 && i < reqK.size(); i++) begin
      checkOutput($sformatf("t3_req_cycle_%0d", i), 64'(reqK[i]), 64'(expK[i]));
      checkOutput($sformatf("t3_req_addr_%0d", i), 64'(reqA[i]), 64'(expA[i]));
    end
    checkOutput("t3_ovf", 64'(fetchOvf), 64'd0);
    en = 1'b0;
    @(negedge clk); checkIdle("t2_disable");

    // Overflow with acknowledge tied low
    ackMode = 0; en = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("t4_ovf_before", 64'(fetchOvf), 64'd0);
    @(negedge clk);
    checkOutput("t4_hcnt", 64'(hcnt), 64'd4);
    checkOutput("t4_ovf", 64'(fetchOvf), 64'd1);
    checkOutput("t4_req_held", 64'(fetchReq), 64'd1);
    checkOutput("t4_addr_held", 64'(fetchAddr), 64'h1000);

    // Disable mid-frame with a request pending, then restart with a new stride
    waitPos(2, 1, 100);
    checkOutput("t6_pending", 64'(fetchReq), 64'd1);
    en = 1'b0;
    @(negedge clk); checkIdle("t6_drop");
    applyStimulus(0, 4, 5, 4, 5, 2, 3, 2, 3, 32'h1000, 32'h40);
    ackMode = 1;
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    checkOutput("t6_entry_req", 64'(fetchReq), 64'd1);
    checkOutput("t6_entry_addr", 64'(fetchAddr), 64'h1000);
    lineinc = 32'h999;
    repeat (4) @(negedge clk);
    checkOutput("t6_next_req", 64'(fetchReq), 64'd1);
    checkOutput("t6_next_addr", 64'(fetchAddr), 64'h1040);
    en = 1'b0;
    @(negedge clk);

    // Pixel divider of three clocks
    applyStimulus(2, 4, 5, 4, 5, 2, 3, 2, 3, 32'h1000, 32'h100);
    en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k < 48) begin hSeq[k] = int'(hcnt); vSeq[k] = int'(vcnt); end
      if (pixStb) stbQ.push_back(k);
    end
    for (int i = 0; i < 4 && i < stbQ.size(); i++)
      checkOutput($sformatf("t5_stb_%0d", i), 64'(stbQ[i]), 64'(expStb[i]));
    checkOutput("t5_stb_count", 64'(stbQ.size()), 64'd13);
    checkOutput("t5_hcnt_k2", 64'(hSeq[2]), 64'd0);
    checkOutput("t5_hcnt_k3", 64'(hSeq[3]), 64'd1);
    checkOutput("t5_hcnt_k17", 64'(hSeq[17]), 64'd5);
    checkOutput("t5_vcnt_k17", 64'(vSeq[17]), 64'd0);
    checkOutput("t5_hcnt_k18", 64'(hSeq[18]), 64'd0);
    checkOutput("t5_vcnt_k18", 64'(vSeq[18]), 64'd1);

    // Reset asserted mid-run overrides everything
    reset = 1'b0;
    @(negedge clk); checkIdle("t5_midreset");
    reset = 1'b1; en = 1'b0;
    @(negedge clk); checkIdle("t5_after_reset");

    // hsize beyond hend: no hblank, only the entry fetch
    applyStimulus(0, 8, 5, 1, 3, 2, 3, 2, 3, 32'h2000, 32'h10);
    ackMode = 1; en = 1'b1;
    reqK.delete(); reqA.delete();
    prevReq = 0; prevAddr = 0; hbCount = 0;
    for (int k = 0; k < 48; k++) begin
      @(negedge clk);
      if (hblank) hbCount++;
      if (fetchReq && (!prevReq || fetchAddr != prevAddr)) begin
        reqK.push_back(k); reqA.push_back(fetchAddr);
      end
      prevReq = fetchReq; prevAddr = fetchAddr;
    end
    checkOutput("t7_hblank_count", 64'(hbCount), 64'd0);
    checkOutput("t7_req_count", 64'(reqK.size()), 64'd1);
    if (reqA.size() >= 1) checkOutput("t7_req_addr", 64'(reqA[0]), 64'h2000);
    en = 1'b0;
    @(negedge clk); checkIdle("t7_disable");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vid_timing_gen.md
Name: vid_timing_gen

Overview:
- Raster timing and line-fetch sequencer for the video controller.
- Consumes the programmed control and timing fields: en, pcnt, hsize/hend, hsync start/end, vsize/vend, vsync start/end, base_address and lineinc.
- Produces hsync/hblank/vsync/vblank, pixel strobes, and one start-address request per displayed line for the bus-master fetch stage.
- Sits between the register file and the pixel/bus-master stage.

Parameters:
CW, 13, width of horizontal/vertical counters and timing fields
AW, 32, width of base_address, lineinc and fetch_addr

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
en  in  1  controller enable (cr.en)
pcnt  in  6  pixel divider; one pixel = pcnt+1 clk cycles
hsize  in  CW  displayed pixels per line
hend  in  CW  last pixel index of line (total = hend+1)
hs_start  in  CW  hsync start pixel
hs_end  in  CW  hsync end pixel (exclusive)
vsize  in  CW  displayed lines per frame
vend  in  CW  last line index of frame
vs_start  in  CW  vsync start line
vs_end  in  CW  vsync end line (exclusive)
base_address  in  AW  frame buffer start address
lineinc  in  AW  byte stride between lines
fetch_ack  in  1  fetch stage accepted fetch_addr
hcnt  out  CW  current pixel index
vcnt  out  CW  current line index
hsync  out  1  active high
hblank  out  1  active high
vsync  out  1  active high
vblank  out  1  active high
pix_stb  out  1  one-clk pulse when counters advance
frame_start  out  1  one-clk pulse when (hcnt,vcnt) becomes (0,0)
fetch_req  out  1  line fetch request
fetch_addr  out  AW  start address of requested line
fetch_ovf  out  1  sticky: request generated while previous pending

Behaviour:
- Reset (reset=0 at clk edge) forces all outputs and internal state to 0 and the FSM to IDLE. Reset applies mid-operation and overrides everything.
- FSM states:
  - IDLE: outputs held 0. When en=1 is sampled, go to RUN, latch all timing/address inputs, and set hcnt=vcnt=0, divider=0, frame_start=1.
  - RUN: when en=0 is sampled, return to IDLE next cycle with all outputs 0 and any pending fetch dropped.
- Latched configuration is used for the whole run. Input changes while in RUN are ignored until the next IDLE->RUN transition.
- Divider:
  - dcnt increments every clk in RUN.
  - On the edge where dcnt==pcnt, dcnt reloads 0 and the counters advance.
  - pix_stb is 1 in the cycle the new counter values first appear.
  - pcnt=0 advances every clk.
- Counters:
  - hcnt counts 0..hend, then wraps to 0.
  - On the hcnt wrap, vcnt increments 0..vend, then wraps to 0.
  - frame_start pulses with the (0,0) wrap.
- Decodes are registered and always consistent with the hcnt/vcnt visible in the same cycle:
  - hblank = hcnt>=hsize
  - vblank = vcnt>=vsize
  - hsync = hs_start<=hcnt<hs_end
  - vsync = vs_start<=vcnt<vs_end
  - Comparisons are unsigned; if end<=start, that sync never asserts.
- Fetch triggers:
  - At RUN entry: line 0, if vsize>0.
  - On each advance where hcnt becomes hsize (hblank entry): next line nl = (vcnt==vend)?0:vcnt+1; request only if nl<vsize.
  - fetch_addr = base_address + nl*lineinc, modulo 2^AW.
- Fetch handshake:
  - fetch_req rises in the same cycle fetch_addr becomes valid.
  - fetch_req and fetch_addr are held stable until fetch_ack=1 is sampled with fetch_req=1; fetch_req is 0 the next cycle.
  - fetch_ack while fetch_req=0 is ignored.
- Simultaneous ack and new trigger in the same cycle: the old request completes and the new request is presented the next cycle with no gap violation. fetch_req stays high and fetch_addr changes.
- Trigger while a request is pending and not acked that cycle: the new request is discarded, the old one is kept, and fetch_ovf is set. fetch_ovf clears only on reset or on IDLE.
- hsize>hend: hblank never asserts and only the entry fetch occurs; this is legal, not an error.

Test Plan:
1. Reset and idle: hold reset=0 for 3 clks with en=1 -> all outputs 0; release reset with en=0 -> outputs stay 0.
2. Basic raster. Config: pcnt=0, hsize=4, hend=5, hs 4..5, vsize=2, vend=3, vs 2..3, then en=1.
   - hcnt sequence 0,1,2,3,4,5,0...
   - hblank=1 at hcnt 4,5; hsync=1 only at hcnt 4.
   - vblank=1 on lines 2,3; vsync=1 on line 2.
   - frame_start every 24 clks.
3. Fetch addresses. Same config with base=0x1000, lineinc=0x100, fetch_ack=1 one cycle after each req:
   - 0x1000 at entry.
   - 0x1100 when line 0 reaches hcnt 4.
   - None on lines 1,2.
   - 0x1000 on line 3 at hcnt 4.
   - fetch_ovf stays 0.
4. Overflow: same config with fetch_ack tied 0 -> the entry request is held at 0x1000; at line 0 hcnt 4, fetch_ovf=1 and fetch_addr is still 0x1000.
5. Divider: pcnt=2 -> each hcnt value lasts 3 clks; pix_stb period is 3; line period is 18 clks.
6. Disable/reset mid-frame: drop en at vcnt=1, hcnt=2 with a req pending -> next cycle all outputs are 0. Re-enable with lineinc=0x40 -> entry fetch is 0x1000 and the new stride is used (0x1040 next).
